// File: rtl/display_scheduler.sv
// Chooses what the four-digit seven-segment driver shows: main content, a timed message overlay, or a blank gap.
// Also generates the blink phase applied to main content.
module display_scheduler #(
  parameter int BLINK_TICKS = 25_000_000,
  parameter int MSG_TICKS   = 200_000_000,
  parameter int GAP_TICKS   = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] main_digits,
  input  logic        main_blink_en,
  input  logic        msg_req,
  input  logic [15:0] msg_digits,
  input  logic        msg_cancel,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        blink
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int MW = (MSG_TICKS > 1) ? $clog2(MSG_TICKS) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [MW-1:0] MSG_MAX   = MW'(MSG_TICKS - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TICKS - 1);
  localparam logic [15:0]   BLANK     = 16'hFFFF;

  typedef enum logic [1:0] {MAIN, MSG, GAP} state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] msg_tmr_q, msg_tmr_d;
  logic [GW-1:0] gap_tmr_q, gap_tmr_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [15:0]   digits_q, digits_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          blink_q, blink_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MAIN;
      msg_tmr_q     <= '0;
      gap_tmr_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digits_q      <= '0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      blink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg_tmr_q     <= msg_tmr_d;
      gap_tmr_q     <= gap_tmr_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digits_q      <= digits_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      blink_q       <= blink_d;
    end
  end

  // Outputs are registered from next-state values so an accepted request shows from the same edge.
  // While in MSG, digits_q itself holds the latched message.
  always_comb begin
    state_d   = state_q;
    msg_tmr_d = msg_tmr_q;
    gap_tmr_d = gap_tmr_q;
    digits_d  = digits_q;
    ack_d     = 1'b0;
    unique case (state_q)
      MAIN: begin
        if (msg_req) begin
          state_d   = MSG;
          msg_tmr_d = '0;
          ack_d     = 1'b1;
          digits_d  = msg_digits;
        end else begin
          digits_d  = main_digits;
        end
      end
      MSG: begin
        if (msg_cancel || (!msg_req && msg_tmr_q == MSG_MAX)) begin
          state_d   = GAP;
          msg_tmr_d = '0;
          gap_tmr_d = '0;
          digits_d  = BLANK;
        end else if (msg_req) begin
          msg_tmr_d = '0;
          ack_d     = 1'b1;
          digits_d  = msg_digits;
        end else begin
          msg_tmr_d = msg_tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_tmr_q == GAP_MAX) begin
          state_d   = MAIN;
          gap_tmr_d = '0;
          digits_d  = main_digits;
        end else begin
          gap_tmr_d = gap_tmr_q + 1'b1;
          digits_d  = BLANK;
        end
      end
      default: begin
        state_d  = MAIN;
        digits_d = main_digits;
      end
    endcase
  end

  // Blink generator is free-running while enabled and held at zero otherwise, so each enable opens visible.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (main_blink_en) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
      end
    end
  end

  always_comb begin
    busy_d  = (state_d != MAIN);
    blink_d = (state_d == MAIN) && main_blink_en && blink_phase_q;
  end

  assign msg_ack  = ack_q;
  assign msg_busy = busy_q;
  assign blink    = blink_q;
  assign digit0   = digits_q[3:0];
  assign digit1   = digits_q[7:4];
  assign digit2   = digits_q[11:8];
  assign digit3   = digits_q[15:12];

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: countdown-based behavioural model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_display_scheduler;
  localparam int B = 4;
  localparam int M = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] main_digits = '0;
  logic        main_blink_en = 1'b0;
  logic        msg_req = 1'b0;
  logic [15:0] msg_digits = '0;
  logic        msg_cancel = 1'b0;
  logic        msg_ack, msg_busy, blink;
  logic [3:0]  digit0, digit1, digit2, digit3;

  int checks = 0;
  int failures = 0;

  display_scheduler #(.BLINK_TICKS(B), .MSG_TICKS(M), .GAP_TICKS(G)) dut (
    .clk(clk), .rst_n(rst_n), .main_digits(main_digits), .main_blink_en(main_blink_en),
    .msg_req(msg_req), .msg_digits(msg_digits), .msg_cancel(msg_cancel),
    .msg_ack(msg_ack), .msg_busy(msg_busy),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0=main, 1=message, 2=gap; remaining-cycle countdowns; blink from enable age.
  int          mode = 0;
  int          msg_left = 0;
  int          gap_left = 0;
  int          en_age = 0;
  logic [15:0] e_dig = '0;
  logic        e_ack = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_blink = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int          nm, nl, ng, na;
    logic [15:0] nd;
    logic        nack;
    if (!rst_n) begin
      mode <= 0; msg_left <= 0; gap_left <= 0; en_age <= 0;
      e_dig <= '0; e_ack <= 1'b0; e_busy <= 1'b0; e_blink <= 1'b0;
    end else begin
      nm = mode; nl = msg_left; ng = gap_left; nd = e_dig; nack = 1'b0;
      if (mode == 0) begin
        if (msg_req) begin nm = 1; nl = M; nd = msg_digits; nack = 1'b1; end
        else nd = main_digits;
      end else if (mode == 1) begin
        if (msg_cancel) begin nm = 2; ng = G; nd = 16'hFFFF; end
        else if (msg_req) begin nl = M; nd = msg_digits; nack = 1'b1; end
        else if (msg_left == 1) begin nm = 2; ng = G; nd = 16'hFFFF; end
        else nl = msg_left - 1;
      end else begin
        if (gap_left == 1) begin nm = 0; nd = main_digits; end
        else begin ng = gap_left - 1; nd = 16'hFFFF; end
      end
      na = main_blink_en ? en_age + 1 : 0;
      mode <= nm; msg_left <= nl; gap_left <= ng; en_age <= na;
      e_dig <= nd; e_ack <= nack; e_busy <= (nm != 0);
      e_blink <= (nm == 0) && main_blink_en && (((na - 1) / B) % 2 == 1);
    end
  end

  always @(negedge clk) begin
    do_check("digits", {16'h0, digit3, digit2, digit1, digit0}, {16'h0, e_dig});
    do_check("msg_ack", {31'h0, msg_ack}, {31'h0, e_ack});
    do_check("msg_busy", {31'h0, msg_busy}, {31'h0, e_busy});
    do_check("blink", {31'h0, blink}, {31'h0, e_blink});
  end

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] bv;
    logic [4:0]  bv5;
    int busy_n, ack_n, blank_n, five_n;

    // Reset and passthrough
    repeat (3) nedge();
    do_check("reset_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0);
    do_check("reset_flags", {29'h0, msg_ack, msg_busy, blink}, 32'h0);
    main_digits = 16'h1234;
    #2 rst_n = 1'b1;
    nedge();
    do_check("pass_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h1234);
    do_check("pass_flags", {30'h0, msg_busy, blink}, 32'h0);

    // Blink pattern
    main_blink_en = 1'b1;
    bv = '0;
    for (int i = 0; i < 12; i++) begin nedge(); bv = {bv[10:0], blink}; end
    do_check("blink_pattern", {20'h0, bv}, {20'h0, 12'b000011110000});
    main_blink_en = 1'b0;
    nedge();
    main_blink_en = 1'b1;
    repeat (6) nedge();
    do_check("blink_mid_one", {31'h0, blink}, 32'h1);
    main_blink_en = 1'b0;
    nedge();
    do_check("blink_drop", {31'h0, blink}, 32'h0);
    main_blink_en = 1'b1;
    bv5 = '0;
    for (int i = 0; i < 5; i++) begin nedge(); bv5 = {bv5[3:0], blink}; end
    do_check("blink_reenable", {27'h0, bv5}, {27'h0, 5'b00001});
    main_blink_en = 1'b0;
    nedge();

    // Single message
    msg_req = 1'b1; msg_digits = 16'h0A0A;
    nedge();
    msg_req = 1'b0;
    do_check("msg_ack_first", {31'h0, msg_ack}, 32'h1);
    do_check("msg_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0A0A);
    busy_n = 1; ack_n = 1; blank_n = 0;
    for (int i = 0; i < 13; i++) begin
      nedge();
      busy_n += msg_busy; ack_n += msg_ack;
      if (msg_busy && digit0 == 4'hF && digit3 == 4'hF) blank_n++;
    end
    do_check("msg_busy_len", busy_n, 10);
    do_check("msg_ack_count", ack_n, 1);
    do_check("gap_len", blank_n, 2);
    do_check("msg_return_main", {16'h0, digit3, digit2, digit1, digit0}, 32'h1234);

    // Retrigger at message cycle 5
    msg_req = 1'b1; msg_digits = 16'h1111;
    nedge();
    msg_req = 1'b0;
    repeat (4) nedge();
    msg_req = 1'b1; msg_digits = 16'h5555;
    nedge();
    msg_req = 1'b0;
    do_check("retrig_ack", {31'h0, msg_ack}, 32'h1);
    five_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (msg_busy && digit0 == 4'h5 && digit3 == 4'h5) five_n++;
      nedge();
    end
    do_check("retrig_len", five_n, 8);
    do_check("retrig_done", {31'h0, msg_busy}, 32'h0);

    // Cancel priority, then request held through GAP
    msg_req = 1'b1; msg_digits = 16'h2222;
    nedge();
    msg_req = 1'b0;
    nedge(); nedge();
    msg_cancel = 1'b1; msg_req = 1'b1; msg_digits = 16'h7777;
    nedge();
    msg_cancel = 1'b0;
    do_check("cancel_no_ack", {31'h0, msg_ack}, 32'h0);
    do_check("cancel_blank", {16'h0, digit3, digit2, digit1, digit0}, 32'hFFFF);
    nedge();
    do_check("gap_hold_no_ack", {30'h0, msg_ack, msg_busy}, 32'h1);
    nedge();
    do_check("gap_back_main", {30'h0, msg_ack, msg_busy}, 32'h0);
    nedge();
    msg_req = 1'b0;
    do_check("held_req_ack", {30'h0, msg_ack, msg_busy}, 32'h3);
    repeat (12) nedge();

    // Reset in the middle of a message
    msg_req = 1'b1; msg_digits = 16'h3333;
    nedge();
    msg_req = 1'b0;
    repeat (3) nedge();
    #2 rst_n = 1'b0;
    #1;
    do_check("midreset_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0);
    do_check("midreset_flags", {29'h0, msg_ack, msg_busy, blink}, 32'h0);
    nedge();
    #2 rst_n = 1'b1;
    ack_n = 0; busy_n = 0;
    for (int i = 0; i < 3; i++) begin nedge(); ack_n += msg_ack; busy_n += msg_busy; end
    do_check("postreset_quiet", ack_n + busy_n, 0);
    do_check("postreset_main", {16'h0, digit3, digit2, digit1, digit0}, 32'h1234);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      msg_req    = ($urandom_range(0, 9) == 0);
      msg_cancel = ($urandom_range(0, 11) == 0);
      msg_digits = 16'($urandom);
      if ($urandom_range(0, 19) == 0) main_blink_en = ~main_blink_en;
      if ($urandom_range(0, 7) == 0) main_digits = 16'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        nedge();
        #2 rst_n = 1'b1;
      end else begin
        nedge();
      end
    end
    msg_req = 1'b0; msg_cancel = 1'b0;
    repeat (2) nedge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
